// File: rtl/im_tile_renderer.sv
// Places one ROM tile per frame at a programmable origin with x1/x2/x4 upscale and optional colour key.
// Latency 3 clocks pixel -> rgb, one pixel per clock, never stalls.

module iob_rom_sp #(
  parameter int    DATA_W  = 32,
  parameter int    ADDR_W  = 13,
  parameter string HEXFILE = "none"
) (
  input  logic              clk,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] r_data
);
  // No file loader in this build: the ROM holds an address-derived image, HEXFILE picks its seed.
  localparam logic [11:0] IMG_SEED = (HEXFILE == "none") ? 12'h5A5 : 12'h000;

  logic [DATA_W-1:0] word;

  always_comb begin
    word = DATA_W'(addr);
    word[11:0] = word[11:0] ^ IMG_SEED;
  end

  always_ff @(posedge clk) begin
    if (r_en) r_data <= word;
  end
endmodule

module im_tile_renderer #(
  parameter int          DATA_W      = 32,
  parameter int          XLEN        = 40,
  parameter int          YLEN        = 40,
  parameter int          NIMG        = 4,
  parameter int          ISEL_W      = 2,
  parameter int          ADDR_W      = $clog2(NIMG*XLEN*YLEN),
  parameter string       HEXFILE     = "none",
  parameter logic [11:0] FRAME_COLOR = 12'hFFF,
  parameter int          KEY_EN      = 0,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              cfg_wr,
  input  logic [9:0]        cfg_x0,
  input  logic [9:0]        cfg_y0,
  input  logic [ISEL_W-1:0] cfg_isel,
  input  logic [1:0]        cfg_scale,
  input  logic              cfg_en,
  output logic              cfg_pending,
  input  logic              pixel_valid,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [11:0]       rgb,
  output logic              rgb_valid,
  output logic              hit
);
  logic [9:0]        pend_x0, pend_y0, act_x0, act_y0;
  logic [ISEL_W-1:0] pend_isel, act_isel;
  logic [1:0]        pend_scale, act_scale;
  logic              pend_en, act_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_x0 <= '0; pend_y0 <= '0; pend_isel <= '0; pend_scale <= '0; pend_en <= 1'b0;
      act_x0  <= '0; act_y0  <= '0; act_isel  <= '0; act_scale  <= '0; act_en  <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_wr) begin
        pend_x0 <= cfg_x0; pend_y0 <= cfg_y0; pend_isel <= cfg_isel;
        pend_scale <= cfg_scale; pend_en <= cfg_en;
      end
      // A write coinciding with frame_start bypasses the pending copy.
      if (frame_start) begin
        if (cfg_wr) begin
          act_x0 <= cfg_x0; act_y0 <= cfg_y0; act_isel <= cfg_isel;
          act_scale <= cfg_scale; act_en <= cfg_en;
        end else begin
          act_x0 <= pend_x0; act_y0 <= pend_y0; act_isel <= pend_isel;
          act_scale <= pend_scale; act_en <= pend_en;
        end
        cfg_pending <= 1'b0;
      end else if (cfg_wr) begin
        cfg_pending <= 1'b1;
      end
    end
  end

  logic [1:0]        shift;
  logic [11:0]       win_w, win_h, px_w, py_w, x0_w, y0_w;
  logic [9:0]        dx, dy, ix, iy;
  logic              isel_ok, in_win;
  logic [ADDR_W-1:0] addr;

  assign shift   = (act_scale == 2'd3) ? 2'd2 : act_scale;
  assign win_w   = 12'(XLEN) << shift;
  assign win_h   = 12'(YLEN) << shift;
  assign px_w    = {2'b00, pixel_x};
  assign py_w    = {2'b00, pixel_y};
  assign x0_w    = {2'b00, act_x0};
  assign y0_w    = {2'b00, act_y0};
  assign isel_ok = 32'(act_isel) < NIMG;
  // 12-bit window compare: a tile running past 1023 is clipped rather than wrapped.
  assign in_win  = act_en & pixel_valid & isel_ok &
                   (px_w >= x0_w) & (px_w < x0_w + win_w) &
                   (py_w >= y0_w) & (py_w < y0_w + win_h);
  assign dx      = pixel_x - act_x0;
  assign dy      = pixel_y - act_y0;
  assign ix      = dx >> shift;
  assign iy      = dy >> shift;
  assign addr    = ADDR_W'(act_isel) * ADDR_W'(XLEN*YLEN) + ADDR_W'(iy) * ADDR_W'(XLEN) + ADDR_W'(ix);

  logic [ADDR_W-1:0] s1_addr;
  logic              s1_win, s1_vld, s2_win, s2_vld;
  logic [DATA_W-1:0] rom_data;
  logic              unused_rom_hi;

  always_ff @(posedge clk) begin
    s1_addr <= addr;
  end

  iob_rom_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HEXFILE(HEXFILE)) u_rom (
    .clk    (clk),
    .r_en   (s1_win),
    .addr   (s1_addr),
    .r_data (rom_data)
  );

  assign unused_rom_hi = ^rom_data[DATA_W-1:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_win <= 1'b0; s1_vld <= 1'b0; s2_win <= 1'b0; s2_vld <= 1'b0;
      rgb <= FRAME_COLOR; rgb_valid <= 1'b0; hit <= 1'b0;
    end else begin
      s1_win <= in_win;  s1_vld <= pixel_valid;
      s2_win <= s1_win;  s2_vld <= s1_vld;
      rgb_valid <= s2_vld;
      if (!s2_win || (KEY_EN != 0 && rom_data[11:0] == KEY_COLOR)) begin
        rgb <= FRAME_COLOR; hit <= 1'b0;
      end else begin
        rgb <= rom_data[11:0]; hit <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_im_tile_renderer.sv
// Randomised and directed bench for im_tile_renderer against a pixel-level model of the tile placement rules.
module tb_im_tile_renderer;
  localparam int XL = 40, YL = 40, NI = 3;

  logic clk = 1'b0;
  logic rst, frame_start, cfg_wr, cfg_en, cfg_pending, pixel_valid, rgb_valid, hit;
  logic [9:0] cfg_x0, cfg_y0, pixel_x, pixel_y;
  logic [1:0] cfg_isel, cfg_scale;
  logic [11:0] rgb;

  always #5 clk = ~clk;

  im_tile_renderer #(
    .DATA_W(32), .XLEN(XL), .YLEN(YL), .NIMG(NI), .ISEL_W(2), .ADDR_W(13),
    .HEXFILE("none"), .FRAME_COLOR(12'hFFF), .KEY_EN(1), .KEY_COLOR(12'hF0F)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_wr(cfg_wr),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_isel(cfg_isel), .cfg_scale(cfg_scale),
    .cfg_en(cfg_en), .cfg_pending(cfg_pending), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .rgb(rgb), .rgb_valid(rgb_valid), .hit(hit)
  );

  int total = 0, bad = 0, hcnt = 0;
  bit chk_on = 0;

  // Model state: configuration registers and the three in-flight pixel results.
  int a_x0, a_y0, a_isel, a_scale, a_en, p_x0, p_y0, p_isel, p_scale, p_en;
  bit m_pend;
  bit pv[3];
  bit ph[3];
  logic [11:0] pr[3];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_pix(input int px, input int py, input bit v,
                                    output bit ov, output logic [11:0] orgb, output bit ohit);
    int s, w, h, ix, iy, a;
    logic [11:0] texel;
    s = (a_scale == 3) ? 2 : a_scale;
    w = XL << s;
    h = YL << s;
    ov = v; orgb = 12'hFFF; ohit = 0;
    if (v && a_en != 0 && a_isel < NI && px >= a_x0 && px < a_x0 + w && py >= a_y0 && py < a_y0 + h) begin
      ix = (px - a_x0) >> s;
      iy = (py - a_y0) >> s;
      a = a_isel * XL * YL + iy * XL + ix;
      texel = 12'(a) ^ 12'h5A5;
      if (texel != 12'hF0F) begin
        orgb = texel; ohit = 1;
      end
    end
  endfunction

  task automatic step();
    bit nv, nh;
    logic [11:0] nr;
    model_pix(int'(pixel_x), int'(pixel_y), pixel_valid, nv, nr, nh);
    @(posedge clk);
    if (rst) begin
      a_x0 = 0; a_y0 = 0; a_isel = 0; a_scale = 0; a_en = 0;
      p_x0 = 0; p_y0 = 0; p_isel = 0; p_scale = 0; p_en = 0;
      m_pend = 0;
      for (int i = 0; i < 3; i++) begin pv[i] = 0; pr[i] = 12'hFFF; ph[i] = 0; end
    end else begin
      pv[2] = pv[1]; pr[2] = pr[1]; ph[2] = ph[1];
      pv[1] = pv[0]; pr[1] = pr[0]; ph[1] = ph[0];
      pv[0] = nv;    pr[0] = nr;    ph[0] = nh;
      if (frame_start) begin
        if (cfg_wr) begin
          a_x0 = cfg_x0; a_y0 = cfg_y0; a_isel = cfg_isel; a_scale = cfg_scale; a_en = cfg_en;
        end else begin
          a_x0 = p_x0; a_y0 = p_y0; a_isel = p_isel; a_scale = p_scale; a_en = p_en;
        end
      end
      if (cfg_wr) begin
        p_x0 = cfg_x0; p_y0 = cfg_y0; p_isel = cfg_isel; p_scale = cfg_scale; p_en = cfg_en;
      end
      m_pend = frame_start ? 1'b0 : (cfg_wr ? 1'b1 : m_pend);
    end
    #1;
    if (hit) hcnt++;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rgb_valid", rgb_valid, pv[2]);
      chk("rgb", rgb, pr[2]);
      chk("hit", hit, ph[2]);
      chk("cfg_pending", cfg_pending, m_pend);
    end
  end

  task automatic write_cfg(input int x0, input int y0, input int isel, input int sc, input int en, input bit fs);
    cfg_x0 = 10'(x0); cfg_y0 = 10'(y0); cfg_isel = 2'(isel); cfg_scale = 2'(sc); cfg_en = en[0];
    cfg_wr = 1; frame_start = fs;
    step();
    cfg_wr = 0; frame_start = 0;
  endtask

  task automatic fstart();
    frame_start = 1;
    step();
    frame_start = 0;
  endtask

  task automatic scan(input int xl, input int xh, input int yl, input int yh);
    hcnt = 0;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        if ($urandom_range(0, 9) == 0) begin
          pixel_valid = 0; pixel_x = 10'($urandom); step();
        end
        pixel_x = 10'(x); pixel_y = 10'(y); pixel_valid = 1;
        step();
      end
    pixel_valid = 0;
    repeat (3) step();
  endtask

  task automatic probe(input int x, input int y, output logic [11:0] r, output bit h);
    pixel_x = 10'(x); pixel_y = 10'(y); pixel_valid = 1;
    step();
    pixel_valid = 0;
    step(); step();
    r = rgb; h = hit;
  endtask

  initial begin
    logic [11:0] r;
    bit h;
    rst = 1; frame_start = 0; cfg_wr = 0; cfg_x0 = 0; cfg_y0 = 0; cfg_isel = 0;
    cfg_scale = 0; cfg_en = 0; pixel_valid = 0; pixel_x = 0; pixel_y = 0;
    step(); step();
    chk("reset_rgb", rgb, 12'hFFF);
    chk("reset_rgb_valid", rgb_valid, 0);
    chk("reset_hit", hit, 0);
    chk("reset_pending", cfg_pending, 0);
    rst = 0;
    chk_on = 1;

    write_cfg(20, 20, 0, 0, 1, 0);
    fstart();
    probe(20, 20, r, h);
    chk("first_texel_rgb", r, 12'h5A5);
    chk("first_texel_hit", h, 1);
    scan(0, 99, 0, 99);
    chk("x1_hit_count", hcnt, 1600);

    write_cfg(100, 50, 2, 1, 1, 1);
    probe(103, 51, r, h);
    chk("x2_texel_3201", r, 12'h924);
    probe(102, 50, r, h);
    chk("x2_texel_same", r, 12'h924);
    scan(96, 183, 48, 133);
    chk("x2_hit_count", hcnt, 6400);

    write_cfg(1000, 0, 0, 2, 1, 1);
    scan(0, 1023, 0, 3);
    chk("clip_hit_count", hcnt, 96);
    scan(0, 135, 0, 3);
    chk("no_wrap_hits", hcnt, 0);

    write_cfg(20, 0, 0, 0, 1, 1);
    scan(0, 99, 0, 0);
    write_cfg(200, 0, 0, 0, 1, 0);
    chk("midframe_pending", cfg_pending, 1);
    scan(0, 99, 1, 1);
    chk("old_origin_hits", hcnt, 40);
    fstart();
    chk("applied_pending", cfg_pending, 0);
    scan(0, 59, 1, 1);
    chk("old_origin_gone", hcnt, 0);
    scan(150, 299, 1, 1);
    chk("new_origin_hits", hcnt, 40);
    write_cfg(500, 0, 0, 0, 1, 1);
    chk("coincident_pending", cfg_pending, 0);
    scan(450, 599, 2, 2);
    chk("coincident_hits", hcnt, 40);

    write_cfg(0, 0, 1, 0, 1, 1);
    probe(10, 28, r, h);
    chk("key_rgb", r, 12'hFFF);
    chk("key_hit", h, 0);
    probe(11, 28, r, h);
    chk("key_neighbour_rgb", r, 12'hF0E);
    chk("key_neighbour_hit", h, 1);

    write_cfg(0, 0, 3, 0, 1, 1);
    scan(0, 49, 0, 9);
    chk("isel_oob_hits", hcnt, 0);

    write_cfg(0, 0, 0, 0, 1, 1);
    pixel_x = 5; pixel_y = 5; pixel_valid = 1; step();
    pixel_x = 6; step();
    pixel_x = 7; rst = 1; step();
    chk("rst_rgb", rgb, 12'hFFF);
    chk("rst_rgb_valid", rgb_valid, 0);
    chk("rst_hit", hit, 0);
    rst = 0;
    scan(0, 39, 0, 3);
    chk("rst_no_hits", hcnt, 0);

    for (int it = 0; it < 25; it++) begin
      int x0, y0, v;
      x0 = $urandom_range(0, 1023);
      y0 = $urandom_range(0, 1023);
      write_cfg(x0, y0, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 4) != 0) ? 1 : 0,
                1'($urandom_range(0, 1)));
      for (int k = 0; k < 300; k++) begin
        v = x0 + int'($urandom_range(0, 200)) - 20;
        pixel_x = 10'((v < 0) ? 0 : v);
        v = y0 + int'($urandom_range(0, 200)) - 20;
        pixel_y = 10'((v < 0) ? 0 : v);
        pixel_valid = ($urandom_range(0, 3) != 0);
        frame_start = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 99) == 0) begin
          cfg_wr = 1; cfg_x0 = 10'($urandom); cfg_y0 = 10'($urandom);
          cfg_isel = 2'($urandom); cfg_scale = 2'($urandom); cfg_en = 1'($urandom);
        end
        step();
        frame_start = 0; cfg_wr = 0;
      end
    end
    pixel_valid = 0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
